mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port SRAM arbiter: FSM states,
// grant encoding and the default access latency.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  localparam int WAIT_DEFAULT = 2;
  localparam int CNT_W        = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one SRAM
// with a fixed access time; ties alternate between the ports.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT = WAIT_DEFAULT,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic [AW-1:0] sram_a,
  output logic          sram_we,
  output logic          sram_re,
  output logic [DW-1:0] sram_dout,
  input  logic [DW-1:0] sram_din,
  output logic          busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT - 1);

  state_e           state;
  grant_e           gnt;
  grant_e           last_grant;
  logic [CNT_W-1:0] cnt;

  grant_e pick;
  logic   pick_we;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick = GNT_I;
    if (i_req && d_req) begin
      pick = (last_grant == GNT_I) ? GNT_D : GNT_I;
    end else if (d_req) begin
      pick = GNT_D;
    end
    // Fetches are always reads, whatever d_we happens to show.
    pick_we = (pick == GNT_D) && d_we;
  end

  // The SRAM-side outputs double as the transaction latch: they are loaded
  // on grant, held through ACCESS and cleared when ACCESS ends.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  // NOTE: the read-data registers are reset too, because they are visible
  // outputs that must read 0 while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      gnt        <= GNT_I;
      last_grant <= GNT_D;
      cnt        <= '0;
      sram_a     <= '0;
      sram_we    <= 1'b0;
      sram_re    <= 1'b0;
      sram_dout  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_req || d_req) begin
            gnt        <= pick;
            last_grant <= pick;
            cnt        <= CNT_LOAD;
            sram_a     <= (pick == GNT_D) ? d_addr : i_addr;
            sram_we    <= pick_we;
            sram_re    <= !pick_we;
            sram_dout  <= pick_we ? d_wdata : '0;
            busy       <= 1'b1;
            state      <= ACCESS;
          end
        end

        ACCESS: begin
          if (cnt == '0) begin
            if (sram_re) begin
              if (gnt == GNT_I) i_rdata <= sram_din;
              else              d_rdata <= sram_din;
            end
            sram_a    <= '0;
            sram_we   <= 1'b0;
            sram_re   <= 1'b0;
            sram_dout <= '0;
            i_ack     <= (gnt == GNT_I);
            d_ack     <= (gnt == GNT_D);
            state     <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          sram_a    <= '0;
          sram_we   <= 1'b0;
          sram_re   <= 1'b0;
          sram_dout <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: stimulus pushes expected acks,
// monitors pop and compare them as the DUTs complete transactions.
module tb_mem_arbiter;

  localparam int WAIT0 = 2;
  localparam int WAIT1 = 1;

  typedef struct {
    logic        port_d;
    logic        is_read;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // DUT 0 (WAIT=2)
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] i_rdata, d_rdata, sram_a, sram_dout, sram_din;
  logic        i_ack, d_ack, sram_we, sram_re, busy;

  // DUT 1 (WAIT=1)
  logic        i_req1 = 1'b0, d_req1 = 1'b0, d_we1 = 1'b0;
  logic [31:0] i_addr1 = '0, d_addr1 = '0, d_wdata1 = '0;
  logic [31:0] i_rdata1, d_rdata1, sram_a1, sram_dout1, sram_din1;
  logic        i_ack1, d_ack1, sram_we1, sram_re1, busy1;

  logic [31:0] mem [256];
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0, e1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter #(.WAIT(WAIT0), .AW(32), .DW(32)) dut0 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .sram_a(sram_a), .sram_we(sram_we), .sram_re(sram_re),
    .sram_dout(sram_dout), .sram_din(sram_din), .busy(busy)
  );

  mem_arbiter #(.WAIT(WAIT1), .AW(32), .DW(32)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_ack(i_ack1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_rdata(d_rdata1), .d_ack(d_ack1),
    .sram_a(sram_a1), .sram_we(sram_we1), .sram_re(sram_re1),
    .sram_dout(sram_dout1), .sram_din(sram_din1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model for DUT 0: word-indexed, written on the strobe edge
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[32'h100 >> 2] = 32'hDEADBEEF;
    mem[32'h080 >> 2] = 32'hCAFE0080;
    mem[32'h090 >> 2] = 32'hBAD00090;
    mem[32'h200 >> 2] = 32'h11112222;
    mem[32'h300 >> 2] = 32'h33334444;
    forever begin
      @(posedge clk);
      if (sram_we) mem[sram_a[9:2]] = sram_dout;
    end
  end

  assign sram_din  = mem[sram_a[9:2]];
  assign sram_din1 = sram_a1 ^ 32'hA5A5_0000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every ack must match the oldest pending expectation
  always @(negedge clk) begin
    if (rst && (i_ack || d_ack)) begin
      if (sb0.size() == 0) begin
        check("dut0_spurious_ack", {62'd0, i_ack, d_ack}, 64'd0);
      end else begin
        e0 = sb0.pop_front();
        check("dut0_ack_both", 64'(i_ack & d_ack), 64'd0);
        check("dut0_ack_port", 64'(d_ack), 64'(e0.port_d));
        check("dut0_ack_cycle", 64'(cyc), 64'(e0.cyc));
        if (e0.is_read)
          check("dut0_rdata", 64'(e0.port_d ? d_rdata : i_rdata), 64'(e0.data));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && (i_ack1 || d_ack1)) begin
      if (sb1.size() == 0) begin
        check("dut1_spurious_ack", {62'd0, i_ack1, d_ack1}, 64'd0);
      end else begin
        e1 = sb1.pop_front();
        check("dut1_ack_port", 64'(d_ack1), 64'(e1.port_d));
        check("dut1_ack_cycle", 64'(cyc), 64'(e1.cyc));
        if (e1.is_read)
          check("dut1_rdata", 64'(e1.port_d ? d_rdata1 : i_rdata1), 64'(e1.data));
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1;
    check("rst_i_rdata", 64'(i_rdata), 64'd0);
    check("rst_d_rdata", 64'(d_rdata), 64'd0);
    check("rst_acks", 64'({i_ack, d_ack}), 64'd0);
    check("rst_strobes", 64'({sram_we, sram_re}), 64'd0);
    check("rst_sram_a", 64'(sram_a), 64'd0);
    check("rst_sram_dout", 64'(sram_dout), 64'd0);
    check("rst_busy", 64'({busy, busy1}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One transaction on DUT 0; the ack itself is checked by the monitor
  task automatic do_txn(input bit port_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data,
                        input bit chg);
    int strobes = 0;
    int bad     = 0;
    bit seen    = 0;
    @(negedge clk);
    if (port_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    sb0.push_back('{port_d, !we, exp_data, cyc + 1 + WAIT0});
    for (int j = 0; j < 30 && !seen; j++) begin
      @(negedge clk);
      if (sram_re || sram_we) begin
        strobes++;
        if (sram_re && sram_we) bad++;
        if (sram_we != we) bad++;
        if (sram_a != addr) bad++;
        if (sram_dout != (we ? wdata : 32'h0)) bad++;
        if (!busy) bad++;
        if (chg) d_addr = 32'h90;
      end else if (sram_a != 32'h0 || sram_dout != 32'h0) begin
        bad++;
      end
      if (i_ack || d_ack) begin
        seen = 1;
        i_req = 1'b0;
        d_req = 1'b0;
      end
    end
    check("txn_ack_seen", 64'(seen), 64'd1);
    check("txn_strobe_cycles", 64'(strobes), 64'(WAIT0));
    check("txn_strobe_values", 64'(bad), 64'd0);
  endtask

  initial begin
    int k;
    int n;
    int strobes;
    bit seen;

    apply_reset();

    // Instruction read, data read with a mid-access address change,
    // data write, then read-back of the written word
    do_txn(1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);
    do_txn(1'b1, 1'b0, 32'h080, 32'h0, 32'hCAFE0080, 1'b1);
    do_txn(1'b1, 1'b1, 32'h040, 32'h12345678, 32'h0, 1'b0);
    check("d_rdata_kept_after_write", 64'(d_rdata), 64'hCAFE0080);
    do_txn(1'b1, 1'b0, 32'h040, 32'h0, 32'h12345678, 1'b0);
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("i_rdata_held", 64'(i_rdata), 64'hDEADBEEF);

    // Both ports held after reset: I, D, I, D, acks four cycles apart
    apply_reset();
    @(negedge clk);
    k = cyc;
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    sb0.push_back('{1'b0, 1'b1, 32'h11112222, k + 3});
    sb0.push_back('{1'b1, 1'b1, 32'h33334444, k + 7});
    sb0.push_back('{1'b0, 1'b1, 32'h11112222, k + 11});
    sb0.push_back('{1'b1, 1'b1, 32'h33334444, k + 15});
    n = 0;
    for (int j = 0; j < 40 && n < 4; j++) begin
      @(negedge clk);
      if (i_ack || d_ack) n++;
      if (n == 4) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
    end
    check("tie_ack_count", 64'(n), 64'd4);

    // Reset asserted during ACCESS aborts with no strobe and no ack
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    check("abort_pre_re", 64'({sram_re, busy}), 64'h3);
    rst = 1'b0;
    #1;
    check("abort_strobes", 64'({sram_we, sram_re}), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_sram_a", 64'(sram_a), 64'd0);
    i_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_ack", 64'({i_ack, d_ack}), 64'd0);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    do_txn(1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);

    // WAIT=1 instance: single-cycle strobe, ack two edges after the request
    @(negedge clk);
    k = cyc;
    d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 32'h44;
    sb1.push_back('{1'b1, 1'b1, 32'hA5A50044, k + 2});
    strobes = 0;
    seen = 0;
    for (int j = 0; j < 20 && !seen; j++) begin
      @(negedge clk);
      if (sram_re1) begin
        strobes++;
        check("w1_sram_a", 64'(sram_a1), 64'h44);
      end
      if (d_ack1 || i_ack1) begin
        seen = 1;
        d_req1 = 1'b0;
      end
    end
    check("w1_ack_seen", 64'(seen), 64'd1);
    check("w1_re_cycles", 64'(strobes), 64'd1);

    repeat (4) @(negedge clk);
    check("sb_drained", 64'(sb0.size() + sb1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
